// File: rtl/data_receiver.sv
// Serial frame receiver: synchronizes an asynchronous line (frame-active, bit clock, data),
// assembles MSB-first frames of WIDTH bits and reports each frame as valid or rejected.
module data_receiver #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             transmission,
  input  logic             clock,
  input  logic             data,
  output logic [WIDTH-1:0] out_data,
  output logic             valid,
  output logic             error,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RECEIVE = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic transSync1_q, transSync2_q, transPrev_q;
  logic clkSync1_q, clkSync2_q, clkPrev_q;
  logic dataSync1_q, dataSync2_q, dataAligned_q;
  logic transRise_q, transFall_q, clkRise_q;
  logic [1:0] prime_q;
  logic edgeEn;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [TW-1:0]    tmoCnt_q, tmoCnt_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  // Edges are suppressed until the previous-value register holds a real sample, so a
  // frame already in progress when reset releases never looks like a fresh rising edge.
  assign edgeEn = (prime_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      transSync1_q  <= 1'b0;
      transSync2_q  <= 1'b0;
      transPrev_q   <= 1'b0;
      clkSync1_q    <= 1'b0;
      clkSync2_q    <= 1'b0;
      clkPrev_q     <= 1'b0;
      dataSync1_q   <= 1'b0;
      dataSync2_q   <= 1'b0;
      dataAligned_q <= 1'b0;
      transRise_q   <= 1'b0;
      transFall_q   <= 1'b0;
      clkRise_q     <= 1'b0;
      prime_q       <= 2'd0;
    end else begin
      transSync1_q  <= transmission;
      transSync2_q  <= transSync1_q;
      transPrev_q   <= transSync2_q;
      clkSync1_q    <= clock;
      clkSync2_q    <= clkSync1_q;
      clkPrev_q     <= clkSync2_q;
      dataSync1_q   <= data;
      dataSync2_q   <= dataSync1_q;
      dataAligned_q <= dataSync2_q;
      transRise_q   <= edgeEn & transSync2_q & ~transPrev_q;
      transFall_q   <= edgeEn & ~transSync2_q & transPrev_q;
      clkRise_q     <= edgeEn & clkSync2_q & ~clkPrev_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  // A bit arriving with the frame end is counted before the length check.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    tmoCnt_d  = tmoCnt_q;
    outData_d = outData_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (transRise_q) begin
          state_d  = RECEIVE;
          shift_d  = '0;
          bitCnt_d = '0;
          tmoCnt_d = '0;
        end
      end
      RECEIVE: begin
        if (clkRise_q && (bitCnt_q == WIDTH_C)) begin
          error_d = 1'b1;
          state_d = DISCARD;
        end else begin
          if (clkRise_q) begin
            shift_d  = {shift_q[WIDTH-2:0], dataAligned_q};
            bitCnt_d = bitCnt_q + CW'(1);
            tmoCnt_d = '0;
          end
          if (transFall_q) begin
            if (bitCnt_d == WIDTH_C) begin
              outData_d = shift_d;
              valid_d   = 1'b1;
            end else begin
              error_d = 1'b1;
            end
            state_d = IDLE;
          end else if (!clkRise_q) begin
            if (tmoCnt_q == TMO_LAST) begin
              error_d = 1'b1;
              state_d = DISCARD;
            end else begin
              tmoCnt_d = tmoCnt_q + TW'(1);
            end
          end
        end
      end
      DISCARD: begin
        if (!transSync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      tmoCnt_q  <= '0;
      outData_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      tmoCnt_q  <= tmoCnt_d;
      outData_q <= outData_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign out_data = outData_q;
  assign valid    = valid_q;
  assign error    = error_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_data_receiver.sv
// Scoreboard bench for data_receiver: each frame pushes its expected outcome, and every
// valid/error pulse pops one entry and is checked against it.
module tb_data_receiver;

  localparam int WIDTH   = 64;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             transmission;
  logic             clock;
  logic             data;
  logic [WIDTH-1:0] out_data;
  logic             valid;
  logic             error;
  logic             busy;

  typedef struct {
    bit          isValid;
    logic [63:0] data;
  } evT;

  evT          expQ[$];
  logic [63:0] lastGood;
  bit          monOn = 1'b0;
  int          checks = 0;
  int          errors = 0;

  data_receiver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock), .data(data),
    .out_data(out_data), .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One line-clock period is 8 clk cycles; data is set up while the line clock is low.
  task automatic applyStimulus(input logic b);
    data  = b;
    clock = 1'b0;
    waitCycles(4);
    clock = 1'b1;
    waitCycles(4);
  endtask

  task automatic sendBits(input logic [63:0] v, input int first, input int n);
    for (int i = first; i < first + n; i++)
      applyStimulus((i < 64) ? v[63-i] : 1'b0);
  endtask

  task automatic startFrame();
    clock        = 1'b0;
    transmission = 1'b1;
    waitCycles(8);
  endtask

  task automatic endFrame();
    transmission = 1'b0;
    clock        = 1'b0;
    waitCycles(10);
  endtask

  task automatic pushEv(input bit isV, input logic [63:0] d);
    evT e;
    e.isValid = isV;
    e.data    = d;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (monOn && (valid || error)) begin
      evT e;
      checkOutput("pulseExclusive", 64'(valid & error), 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", {62'd0, valid, error}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulseKind", 64'(valid), 64'(e.isValid));
        checkOutput("outData", out_data, e.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] v1, v2, v3, vA, vB, vC, vD;
    int lat, errAt;
    v1 = 64'h80C0E0F0F8FCFEFF;
    v2 = 64'h0123456789ABCDEF;
    v3 = 64'hDEADBEEFCAFEF00D;
    vA = 64'hAAAA5555AAAA5555;
    vB = 64'h13579BDF2468ACE0;
    vC = 64'hF0E1D2C3B4A59687;
    vD = {$urandom, $urandom};

    rst = 1'b1; transmission = 1'b0; clock = 1'b0; data = 1'b0;
    waitCycles(3);
    checkOutput("resetOutData", out_data, 64'd0);
    checkOutput("resetValid", 64'(valid), 64'd0);
    checkOutput("resetError", 64'(error), 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    rst = 1'b0;
    waitCycles(5);
    monOn    = 1'b1;
    lastGood = 64'd0;

    // Full frame with latency measurement on the frame end
    startFrame();
    pushEv(1'b1, v1);
    sendBits(v1, 0, 64);
    checkOutput("busyReceive", 64'(busy), 64'd1);
    transmission = 1'b0;
    clock        = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid && lat == 0) lat = k;
    end
    checkOutput("validLatency", 64'(lat), 64'd4);
    waitCycles(4);
    lastGood = v1;
    checkOutput("busyAfterFrame", 64'(busy), 64'd0);

    // Short frame is rejected, out_data retained
    startFrame();
    pushEv(1'b0, lastGood);
    sendBits(v2, 0, 63);
    endFrame();
    checkOutput("outDataKept", out_data, lastGood);

    // Overlong frame: error on the 65th edge, stays busy until the frame ends
    startFrame();
    pushEv(1'b0, lastGood);
    sendBits(v3, 0, 65);
    waitCycles(8);
    checkOutput("busyDiscardLong", 64'(busy), 64'd1);
    endFrame();
    checkOutput("busyIdleLong", 64'(busy), 64'd0);

    // Stalled line clock after 10 bits
    startFrame();
    pushEv(1'b0, lastGood);
    sendBits(v2, 0, 9);
    data  = v2[54];
    clock = 1'b0;
    waitCycles(4);
    clock = 1'b1;
    errAt = 0;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (error && errAt == 0) errAt = k;
    end
    checkOutput("timeoutDelay", 64'(errAt), 64'(TIMEOUT + 4));
    checkOutput("busyDiscardTmo", 64'(busy), 64'd1);
    endFrame();
    checkOutput("busyIdleTmo", 64'(busy), 64'd0);

    // Reset mid-frame; the rest of that frame must be ignored
    startFrame();
    sendBits(vA, 0, 30);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    lastGood = 64'd0;
    sendBits(vA, 30, 34);
    checkOutput("busyAfterReset", 64'(busy), 64'd0);
    endFrame();
    checkOutput("outDataAfterReset", out_data, 64'd0);
    startFrame();
    pushEv(1'b1, vB);
    sendBits(vB, 0, 64);
    endFrame();
    lastGood = vB;

    // Last bit and frame end arrive together
    startFrame();
    pushEv(1'b1, vC);
    sendBits(vC, 0, 63);
    data  = vC[0];
    clock = 1'b0;
    waitCycles(4);
    clock        = 1'b1;
    transmission = 1'b0;
    waitCycles(10);
    clock = 1'b0;
    waitCycles(4);
    lastGood = vC;

    startFrame();
    pushEv(1'b1, vD);
    sendBits(vD, 0, 64);
    endFrame();
    lastGood = vD;

    waitCycles(20);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    checkOutput("finalOutData", out_data, lastGood);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
